// File: rtl/lut_eval_pkg.sv
// Shared types and default sizing for the LUT evaluation engine.
package lut_eval_pkg;

    localparam int unsigned N_IN_DEF  = 5;
    localparam int unsigned N_OUT_DEF = 4;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_e;

endpackage

// File: rtl/lut_eval_table.sv
// Flop-based truth table: 2**N_IN rows of N_OUT bits with one write port and one clear port.
module lut_eval_table
    import lut_eval_pkg::*;
#(
    parameter int unsigned N_IN  = N_IN_DEF,
    parameter int unsigned N_OUT = N_OUT_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             we,
    input  logic [N_IN-1:0]                  waddr,
    input  logic [N_OUT-1:0]                 wdata,
    input  logic                             clr,
    input  logic [N_IN-1:0]                  caddr,
    output logic [2**N_IN-1:0][N_OUT-1:0]    rows
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows <= '0;
        end else begin
            // The controller never asserts we and clr together.
            if (we) begin
                rows[waddr] <= wdata;
            end
            if (clr) begin
                rows[caddr] <= '0;
            end
        end
    end

endmodule

// File: rtl/lut_eval_engine.sv
// Table-driven boolean function evaluator with row config, sequential clear and optional
// registered readback (enabled by defining LUT_READBACK_EN).
module lut_eval_engine
    import lut_eval_pkg::*;
#(
    parameter int unsigned N_IN  = N_IN_DEF,
    parameter int unsigned N_OUT = N_OUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    output logic [N_OUT-1:0] out_vec,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic [N_OUT-1:0] cfg_data,
    input  logic             cfg_clr,
    output logic             busy,
    input  logic [N_IN-1:0]  rb_addr,
    output logic [N_OUT-1:0] rb_data
);

    localparam int unsigned DEPTH = 2 ** N_IN;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    state_e                          state_q;
    logic [CW-1:0]                   cnt_q;
    logic                            rdy_q;
    logic                            busy_q;
    logic                            out_valid_q;
    logic [N_OUT-1:0]                out_vec_q;
    logic [DEPTH-1:0][N_OUT-1:0]     rows;
    logic                            eval_acc;
    logic                            tbl_we;
    logic                            tbl_clr;

    assign eval_acc = in_valid & rdy_q;
    // A clear request wins over a coincident write; the write is dropped.
    assign tbl_we   = cfg_valid & rdy_q & ~cfg_clr;
    assign tbl_clr  = (state_q == CLEAR);

    lut_eval_table #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (tbl_we),
        .waddr (cfg_addr),
        .wdata (cfg_data),
        .clr   (tbl_clr),
        .caddr (cnt_q[N_IN-1:0]),
        .rows  (rows)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
        end else begin
            out_valid_q <= eval_acc;
            if (eval_acc) begin
                out_vec_q <= rows[in_vec];
            end
            unique case (state_q)
                IDLE: begin
                    if (cfg_clr) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                        rdy_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end else begin
                        rdy_q   <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        rdy_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = rdy_q;
    assign cfg_ready = rdy_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_vec   = out_vec_q;

`ifdef LUT_READBACK_EN
    logic [N_OUT-1:0] rb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_q <= '0;
        end else begin
            rb_q <= rows[rb_addr];
        end
    end

    assign rb_data = rb_q;
`else
    logic unused_rb;
    assign unused_rb = ^rb_addr;
    assign rb_data   = '0;
`endif

endmodule

// File: doc/lut_eval_engine.md
LUT_EVAL_ENGINE -- requirements
Module: lut_eval_engine

Interface
REQ-001 The block SHALL have parameter N_IN, default 5, meaning the number of function inputs (legal range 2..8).
REQ-002 The block SHALL have parameter N_OUT, default 4, meaning the number of function outputs (legal range 1..16).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: an input vector is presented.
REQ-006 Port in_ready, output, 1 bit: the engine accepts in_vec this cycle.
REQ-007 Port in_vec, input, N_IN bits: the minterm index to evaluate.
REQ-008 Port out_valid, output, 1 bit: out_vec holds a fresh result this cycle.
REQ-009 Port out_vec, output, N_OUT bits: the evaluated function outputs, bit k = F(k).
REQ-010 Port cfg_valid, input, 1 bit: a table row write is requested.
REQ-011 Port cfg_ready, output, 1 bit: a row write is accepted this cycle.
REQ-012 Port cfg_addr, input, N_IN bits: the row (minterm) to write.
REQ-013 Port cfg_data, input, N_OUT bits: the output values for that row.
REQ-014 Port cfg_clr, input, 1 bit: a one-cycle pulse starts a full-table clear.
REQ-015 Port busy, output, 1 bit: asserted while a clear is in progress.
REQ-016 Port rb_addr, input, N_IN bits: the readback row address.
REQ-017 Port rb_data, output, N_OUT bits: the readback row contents.

Function
REQ-018 The table SHALL be 2**N_IN rows by N_OUT bits of flops, and SHALL implement any N_OUT boolean functions of N_IN inputs.
REQ-019 The FSM SHALL have states IDLE and CLEAR; reset enters IDLE.
REQ-020 In IDLE, in_ready and cfg_ready SHALL both be 1 and busy SHALL be 0.
REQ-021 An evaluation is accepted on in_valid&&in_ready; on the next cycle out_valid=1 and out_vec=table[in_vec] as of the acceptance edge (latency 1, back-to-back every cycle).
REQ-022 out_valid SHALL be 0 in any cycle following a cycle with no accepted input; out_vec SHALL hold its last value.
REQ-023 A write is accepted on cfg_valid&&cfg_ready and SHALL be visible to evaluations accepted from the next cycle onwards.
REQ-024 A simultaneous write and evaluation of the same row SHALL return the old row contents.
REQ-025 A cfg_clr pulse in IDLE SHALL enter CLEAR with counter=0; each cycle, row[counter] is zeroed and the counter increments.
REQ-026 CLEAR SHALL return to IDLE after row 2**N_IN-1 is cleared, i.e. exactly 2**N_IN cycles in CLEAR.
REQ-027 In CLEAR, in_ready=0, cfg_ready=0 and busy=1; cfg_clr in CLEAR SHALL be ignored.
REQ-028 A cfg_clr pulse coinciding with an accepted write or evaluation SHALL take priority: that write is discarded, while the evaluation completes using pre-clear data.
REQ-029 The clear counter SHALL be $clog2(2**N_IN)+1 bits so that the terminal compare does not wrap.

Reset
REQ-030 Asserting rst_n low SHALL asynchronously force the FSM to IDLE, all table rows, out_vec and rb_data to 0, and out_valid and busy to 0.
REQ-031 Reset asserted mid-CLEAR SHALL abort the clear; the table SHALL be all-zero on release regardless.
REQ-032 in_ready and cfg_ready SHALL be 0 while rst_n is low and SHALL be 1 on the first cycle after release.

Configuration
REQ-033 With macro LUT_READBACK_EN defined, rb_data SHALL register table[rb_addr] each cycle (latency 1, reflecting writes accepted up to the previous edge).
REQ-034 Without LUT_READBACK_EN, the ports SHALL remain present, rb_data SHALL be constant 0, and no readback mux SHALL be synthesised.

Structure
REQ-035 Package lut_eval_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and the default constants N_IN_DEF=5 and N_OUT_DEF=4.
REQ-036 The table storage with its write and clear ports SHALL be one sub-module, lut_eval_table; the FSM and pipeline SHALL live in the top module.

Verification (N_IN=5, N_OUT=4)
REQ-037 Write row 5'b01101=4'b1010, then evaluate 5'b01101 -> next cycle out_valid=1 and out_vec=4'b1010.
REQ-038 Write row 3=4'hF and evaluate row 3 in the same cycle -> out_vec=4'h0; re-evaluate the next cycle -> 4'hF.
REQ-039 Fill all 32 rows with 4'h5 and pulse cfg_clr -> busy=1 and in_ready=0 for exactly 32 cycles; any evaluation afterwards -> 4'h0.
REQ-040 Drive rst_n low at clear cycle 10, then release -> busy=0, in_ready=1, all rows read 0.
REQ-041 Stream 32 consecutive inputs 0..31 -> 32 consecutive out_valid pulses in order; an idle cycle -> out_valid=0 with out_vec held.
REQ-042 With LUT_READBACK_EN, write row 7=4'h9 and set rb_addr=7 -> rb_data=4'h9 on the second edge; without the macro -> rb_data=0.
